// File: rtl/csr_spmv_pkg.sv
// Shared types and constants for the CSR sparse-matrix x dense-multivector engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package csr_spmv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PTR0,
        ST_PTR,
        ST_STREAM,
        ST_DRAIN,
        ST_EMIT,
        ST_FIN
    } state_t;

    // Cycles from the last nonzero issue until its product lands in the accumulator.
    localparam int PIPE_DEPTH = 4;

    // Raw widths of the row-pointer and column-index RAM words.
    localparam int RP_W  = 32;
    localparam int COL_W = 32;

    // Bit offset of a lane's slice inside a lane-packed bus (lane 0 in the LSBs).
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/spmv_mac_lane.sv
// One lane of the multiply-accumulate datapath: registered signed product, then accumulate.
// Latency: product one cycle after mul_en, accumulator one cycle after acc_en.
// Backpressure: none; the controller only strobes when operands are valid.
module spmv_mac_lane
    import csr_spmv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] val,
    input  logic [DATA_W-1:0] vec,
    input  logic              mul_en,
    input  logic              acc_en,
    input  logic              clr,
    output logic [ACC_W-1:0]  acc
);

    logic [ACC_W-1:0] val_x;
    logic [ACC_W-1:0] vec_x;
    logic [ACC_W-1:0] mul;
    logic [ACC_W-1:0] prod;

    // Sign-extend both operands to the accumulator width; the low ACC_W bits of
    // their product are the exact signed product since ACC_W >= 2*DATA_W.
    always_comb begin
        val_x = {{(ACC_W-DATA_W){val[DATA_W-1]}}, val};
        vec_x = {{(ACC_W-DATA_W){vec[DATA_W-1]}}, vec};
        mul   = val_x * vec_x;
    end

    // Product register, then wrapping accumulate with a synchronous clear at row start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod <= '0;
            acc  <= '0;
        end else begin
            if (mul_en) begin
                prod <= mul;
            end
            if (clr) begin
                acc <= '0;
            end else if (acc_en) begin
                acc <= acc + prod;
            end
        end
    end

endmodule

// File: rtl/csr_spmv_lanes.sv
// CSR SpMV engine: walks row pointers, streams nonzeros, MACs LANES dense columns per row.
// Latency: per row 4 pointer cycles + nnz issue cycles + 4 drain cycles, then EMIT.
// Backpressure: EMIT holds out_* stable until out_ready; the next row never starts before.
module csr_spmv_lanes
    import csr_spmv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 64,
    parameter int LANES  = 2,
    parameter int ROW_AW = 10,
    parameter int NNZ_AW = 14,
    parameter int COL_AW = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ROW_AW-1:0]       num_rows,
    output logic                    busy,
    output logic                    done,
    output logic [ROW_AW-1:0]       rowptr_addr,
    input  logic [RP_W-1:0]         rowptr_data,
    output logic [NNZ_AW-1:0]       nnz_addr,
    input  logic [DATA_W-1:0]       val_data,
    input  logic [COL_W-1:0]        col_data,
    output logic [COL_AW-1:0]       vec_addr,
    input  logic [LANES*DATA_W-1:0] vec_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ROW_AW-1:0]       out_row,
    output logic [LANES*ACC_W-1:0]  out_data,
    output logic                    out_zero
);

    localparam int DCW = $clog2(PIPE_DEPTH);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(PIPE_DEPTH - 1);

    state_t              state;
    logic                phase;      // 0: address presented, 1: RAM data valid
    logic [ROW_AW-1:0]   r;
    logic [ROW_AW-1:0]   nrows;
    logic [NNZ_AW-1:0]   beg_ptr;
    logic [NNZ_AW-1:0]   end_ptr;
    logic [DCW-1:0]      drain_cnt;

    // Per-nonzero pipeline strobes and the value delayed to meet its vector element.
    logic                p1, p2, p3, p4;
    logic [DATA_W-1:0]   val_q1, val_q2;

    logic                acc_clr;
    logic [NNZ_AW-1:0]   rp_trunc;

    // Only the low bits of row pointers and column indices address anything.
    logic                unused_bits;
    assign unused_bits = ^{rowptr_data[RP_W-1:NNZ_AW], col_data[COL_W-1:COL_AW]};

    assign rp_trunc = rowptr_data[NNZ_AW-1:0];
    // Accumulators clear as each row's end pointer arrives, empty rows included,
    // so an empty row emits zeros straight from the accumulators.
    assign acc_clr  = (state == ST_PTR) && phase;

    // Control FSM: pointer fetch, nonzero issue, drain, result handshake, completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            phase       <= 1'b0;
            r           <= '0;
            nrows       <= '0;
            beg_ptr     <= '0;
            end_ptr     <= '0;
            drain_cnt   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rowptr_addr <= '0;
            nnz_addr    <= '0;
            out_valid   <= 1'b0;
            out_zero    <= 1'b0;
            out_row     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        nrows       <= num_rows;
                        r           <= '0;
                        rowptr_addr <= '0;
                        phase       <= 1'b0;
                        busy        <= 1'b1;
                        if (num_rows == '0) begin
                            done  <= 1'b1;
                            state <= ST_FIN;
                        end else begin
                            state <= ST_PTR0;
                        end
                    end
                end
                ST_PTR0: begin
                    if (!phase) begin
                        phase <= 1'b1;
                    end else begin
                        beg_ptr     <= rp_trunc;
                        rowptr_addr <= r + ROW_AW'(1);
                        phase       <= 1'b0;
                        state       <= ST_PTR;
                    end
                end
                ST_PTR: begin
                    if (!phase) begin
                        phase <= 1'b1;
                    end else begin
                        phase   <= 1'b0;
                        end_ptr <= rp_trunc;
                        out_row <= r;
                        if (rp_trunc == beg_ptr) begin
                            out_zero  <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= ST_EMIT;
                        end else begin
                            nnz_addr <= beg_ptr;
                            state    <= ST_STREAM;
                        end
                    end
                end
                ST_STREAM: begin
                    if ((nnz_addr + NNZ_AW'(1)) == end_ptr) begin
                        drain_cnt <= '0;
                        state     <= ST_DRAIN;
                    end else begin
                        nnz_addr <= nnz_addr + NNZ_AW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        out_zero  <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= ST_EMIT;
                    end else begin
                        drain_cnt <= drain_cnt + DCW'(1);
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        out_zero    <= 1'b0;
                        beg_ptr     <= end_ptr;
                        r           <= r + ROW_AW'(1);
                        rowptr_addr <= r + ROW_AW'(2);
                        if ((r + ROW_AW'(1)) == nrows) begin
                            done  <= 1'b1;
                            state <= ST_FIN;
                        end else begin
                            state <= ST_PTR;
                        end
                    end
                end
                ST_FIN: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Nonzero pipeline: value/column capture, vector address, value alignment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p1       <= 1'b0;
            p2       <= 1'b0;
            p3       <= 1'b0;
            p4       <= 1'b0;
            vec_addr <= '0;
            val_q1   <= '0;
            val_q2   <= '0;
        end else begin
            p1 <= (state == ST_STREAM);
            p2 <= p1;
            p3 <= p2;
            p4 <= p3;
            if (p1) begin
                vec_addr <= col_data[COL_AW-1:0];
                val_q1   <= val_data;
            end
            if (p2) begin
                val_q2 <= val_q1;
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        spmv_mac_lane #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .val    (val_q2),
            .vec    (vec_data[lane_lsb(g, DATA_W) +: DATA_W]),
            .mul_en (p3),
            .acc_en (p4),
            .clr    (acc_clr),
            .acc    (out_data[lane_lsb(g, ACC_W) +: ACC_W])
        );
    end

endmodule
